// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the 2x2 mesh NoC router blocks: flit geometry,
// field positions inside a 14-bit flit, the output arbiter state type and
// a packed view of a flit.
// Optional feature macro used by the output arbiter: NOC_ARB_STATS_EN.
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int NUM_IN = 4;
    localparam int PKT_W  = 14;
    localparam int CNT_W  = 16;

    // Flit field positions: [13] rsvd, [12:11] dst, [10:9] type, [8:1] payload, [0] eop
    localparam int RSVD_BIT    = 13;
    localparam int DST_MSB     = 12;
    localparam int DST_LSB     = 11;
    localparam int TYPE_MSB    = 10;
    localparam int TYPE_LSB    = 9;
    localparam int PAYLOAD_MSB = 8;
    localparam int PAYLOAD_LSB = 1;
    localparam int EOP_BIT     = 0;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic       rsvd;
        logic [1:0] dst_addr;
        logic [1:0] pack_t;
        logic [7:0] payload;
        logic       eop;
    } noc_flit_t;

    // True when the flit closes its packet.
    function automatic logic flit_is_eop(input noc_flit_t flit);
        return flit.eop;
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter
// Combinational round-robin picker. Returns the first requesting index found
// when scanning cyclically upward starting at ptr_i.
// Ports:
//   req_i    [NUM_IN]  request vector
//   ptr_i    [IDX_W]   index with highest priority this cycle
//   winner_o [IDX_W]   selected index (0 when nothing requests)
//   found_o  1         at least one request present
// -----------------------------------------------------------------------------
module noc_rr_arbiter #(
    parameter  int NUM_IN = 4,
    localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [IDX_W-1:0]  winner_o,
    output logic              found_o
);

    // Cyclic priority scan starting at ptr_i.
    always_comb begin
        int idx;
        idx      = 0;
        winner_o = '0;
        found_o  = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = (int'(ptr_i) + k) % NUM_IN;
            if (!found_o && req_i[idx[IDX_W-1:0]]) begin
                found_o  = 1'b1;
                winner_o = idx[IDX_W-1:0];
            end else begin
                found_o  = found_o;
            end
        end
    end

endmodule

// File: rtl/noc_router_output_arbiter.sv
// -----------------------------------------------------------------------------
// noc_router_output_arbiter
// Output stage of one router port. Round-robin arbitration among NUM_IN
// inputs, wormhole lock on the winner until its eop flit passes, and a single
// registered output stage with valid/ready backpressure.
// Optional feature: define NOC_ARB_STATS_EN to build saturating statistics
// counters; otherwise pkt_count/stall_count are tied to zero.
// Ports:
//   clk, rst (async, active low)
//   in_valid    [NUM_IN]        per-input flit valid
//   in_packet   [NUM_IN*PKT_W]  flattened flits, input i at [i*PKT_W +: PKT_W]
//   in_ready    [NUM_IN]        per-input accept
//   out_valid / out_packet      registered output flit
//   out_ready                   downstream accept
//   grant_id    [IDX_W]         owner when locked, winner when idle
//   busy                        high while locked
//   pkt_count   [NUM_IN*CNT_W]  per-input forwarded packet count
//   stall_count [CNT_W]         cycles with out_valid && !out_ready
// -----------------------------------------------------------------------------
module noc_router_output_arbiter #(
    parameter  int NUM_IN = 4,
    parameter  int PKT_W  = 14,
    parameter  int CNT_W  = 16,
    localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*PKT_W-1:0] in_packet,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [PKT_W-1:0]        out_packet,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    busy,
    output logic [NUM_IN*CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0]        stall_count
);

    import noc_pkg::*;

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               out_valid_q, out_valid_d;
    logic [PKT_W-1:0]   out_packet_q, out_packet_d;

    logic [PKT_W-1:0]   flit_s [NUM_IN];
    logic [IDX_W-1:0]   winner_s;
    logic               found_s;
    logic [IDX_W-1:0]   sel_s;
    logic               sel_active_s;
    logic [PKT_W-1:0]   sel_flit_s;
    logic               sel_eop_s;
    logic               can_accept_s;
    logic               xfer_s;
    logic [NUM_IN-1:0]  in_ready_s;

    // Wrap-around increment used to advance the round-robin pointer.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_IN - 1)) begin
            return '0;
        end else begin
            return idx + IDX_W'(1);
        end
    endfunction

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign flit_s[g] = in_packet[g*PKT_W +: PKT_W];
    end

    noc_rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_rr (
        .req_i    (in_valid),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner_s),
        .found_o  (found_s)
    );

    assign can_accept_s = !out_valid_q || out_ready;

    // Source selection: the owner while locked, otherwise the round-robin winner.
    always_comb begin
        sel_s        = winner_s;
        sel_active_s = found_s;
        grant_d      = grant_q;
        if (state_q == ARB_LOCKED) begin
            sel_s        = owner_q;
            sel_active_s = 1'b1;
            grant_d      = owner_q;
        end else if (found_s) begin
            grant_d      = winner_s;
        end else begin
            grant_d      = grant_q;
        end
    end

    assign sel_flit_s = flit_s[sel_s];
    assign sel_eop_s  = flit_is_eop(noc_flit_t'(sel_flit_s));
    assign xfer_s     = sel_active_s && can_accept_s && in_valid[sel_s];

    // Only the selected input may be offered a ready; everyone else is blocked.
    always_comb begin
        in_ready_s = '0;
        if (sel_active_s && can_accept_s) begin
            in_ready_s[sel_s] = 1'b1;
        end else begin
            in_ready_s = '0;
        end
    end

    // Next-state logic for output register, lock state and round-robin pointer.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        out_valid_d  = out_valid_q;
        out_packet_d = out_packet_q;

        // A new flit overwrites the register even when the old one is leaving.
        if (xfer_s) begin
            out_valid_d  = 1'b1;
            out_packet_d = sel_flit_s;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end else begin
            out_valid_d  = out_valid_q;
        end

        case (state_q)
            ARB_IDLE: begin
                if (xfer_s && sel_eop_s) begin
                    rr_ptr_d = next_idx(sel_s);
                end else if (xfer_s) begin
                    state_d  = ARB_LOCKED;
                    owner_d  = sel_s;
                end else begin
                    state_d  = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                // Release only on the owner's eop; re-arbitration waits a cycle.
                if (xfer_s && sel_eop_s) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = next_idx(owner_q);
                end else begin
                    state_d  = ARB_LOCKED;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, pointer and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            out_valid_q  <= out_valid_d;
            out_packet_q <= out_packet_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign out_packet = out_packet_q;
    assign grant_id   = grant_d;
    assign busy       = (state_q == ARB_LOCKED);

`ifdef NOC_ARB_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of cycles where the output is held by downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign stall_count = stall_cnt_q;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_pkt_cnt
        logic [CNT_W-1:0] pkt_cnt_q;

        // Saturating count of eop flits forwarded from this input.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pkt_cnt_q <= '0;
            end else if (xfer_s && sel_eop_s && (sel_s == IDX_W'(g)) && (pkt_cnt_q != '1)) begin
                pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            end else begin
                pkt_cnt_q <= pkt_cnt_q;
            end
        end

        assign pkt_count[g*CNT_W +: CNT_W] = pkt_cnt_q;
    end
`else
    assign stall_count = '0;
    assign pkt_count   = '0;
`endif

endmodule

// File: tb/tb_noc_router_output_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_router_output_arbiter
// Randomized and directed stimulus for noc_router_output_arbiter. A reference
// model of the arbitration rules predicts handshakes each cycle; predicted
// output flits go to a scoreboard queue that a separate monitor drains.
// -----------------------------------------------------------------------------
module tb_noc_router_output_arbiter;

    localparam int N  = 4;
    localparam int W  = 14;
    localparam int CW = 16;
    localparam int SRC_DEPTH = 128;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_packet;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_packet;
    logic            out_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic [N*CW-1:0] pkt_count;
    logic [CW-1:0]   stall_count;

    always #5 clk = ~clk;

    noc_router_output_arbiter #(.NUM_IN(N), .PKT_W(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_packet   (in_packet),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_packet  (out_packet),
        .out_ready   (out_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .pkt_count   (pkt_count),
        .stall_count (stall_count)
    );

    int checks = 0;
    int errors = 0;

    // Flits the DUT output register is expected to hold, oldest first.
    logic [W-1:0] sb [$];

    // Upstream sources: one flit FIFO per input.
    logic [W-1:0] src_mem [N][SRC_DEPTH];
    int           src_rd [N];
    int           src_wr [N];

    int           p_valid [N];
    int           p_ready;
    logic [N-1:0] block_mask;

    // Reference model state.
    bit m_locked;
    int m_owner;
    int m_ptr;
    int m_grant;
    int m_pkt [N];
    int m_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cnt_exp(input int v);
`ifdef NOC_ARB_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic add_flit(input int i, input logic [W-1:0] f);
        src_mem[i][src_wr[i] % SRC_DEPTH] = f;
        src_wr[i]++;
    endtask

    task automatic add_pkt(input int i, input int len);
        logic [W-1:0] f;
        for (int k = 0; k < len; k++) begin
            f = W'($urandom);
            f[0] = (k == len - 1);
            add_flit(i, f);
        end
    endtask

    // One clock cycle: drive, predict, compare, then advance the model.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        logic [W-1:0] f;
        bit ca, act, xfer, stall;
        int sel, exp_grant;
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            in_valid[i] = (src_rd[i] < src_wr[i]) && !block_mask[i] &&
                          ($urandom_range(0, 99) < p_valid[i]);
            in_packet[i*W +: W] = (src_rd[i] < src_wr[i]) ?
                                  src_mem[i][src_rd[i] % SRC_DEPTH] : W'($urandom);
        end
        out_ready = ($urandom_range(0, 99) < p_ready);
        #1;
        ca  = (sb.size() == 0) || out_ready;
        act = 1'b0;
        sel = 0;
        if (m_locked) begin
            act = 1'b1;
            sel = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!act && in_valid[(m_ptr + k) % N]) begin
                    act = 1'b1;
                    sel = (m_ptr + k) % N;
                end
            end
        end
        exp_grant = act ? sel : m_grant;
        exp_ready = '0;
        if (act && ca) exp_ready[sel] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("busy", 64'(busy), 64'(m_locked));
        check("grant_id", 64'(grant_id), 64'(exp_grant));
        check("stall_count", 64'(stall_count), 64'(cnt_exp(m_stall)));
        for (int i = 0; i < N; i++) begin
            check("pkt_count", 64'(pkt_count[i*CW +: CW]), 64'(cnt_exp(m_pkt[i])));
        end
        xfer  = act && ca && in_valid[sel];
        stall = (sb.size() != 0) && !out_ready;
        f     = in_packet[sel*W +: W];
        @(posedge clk);
        if (stall) m_stall++;
        m_grant = exp_grant;
        if (xfer) begin
            sb.push_back(f);
            src_rd[sel]++;
            if (f[0]) begin
                m_pkt[sel]++;
                m_locked = 1'b0;
                m_ptr    = (sel + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = sel;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_packet", 64'(out_packet), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_stall_count", 64'(stall_count), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        sb.delete();
        for (int i = 0; i < N; i++) begin
            src_rd[i] = src_wr[i];
            m_pkt[i]  = 0;
        end
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_grant  = 0;
        m_stall  = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_lock(input int owner, input int budget);
        int n;
        n = 0;
        while (!(m_locked && m_owner == owner) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (!(m_locked && m_owner == owner)) begin
            errors++;
            $display("FAIL wait_lock owner=%0d not reached within %0d cycles", owner, budget);
        end
    endtask

    function automatic bit sources_empty();
        for (int i = 0; i < N; i++) begin
            if (src_rd[i] < src_wr[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Monitor: the output register must match the scoreboard head each cycle.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
                if (sb.size() != 0) begin
                    check("out_packet", 64'(out_packet), 64'(sb[0]));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, n;
        in_valid   = '0;
        in_packet  = '0;
        out_ready  = 1'b0;
        block_mask = '0;
        p_ready    = 100;
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 0;
            src_rd[i]  = 0;
            src_wr[i]  = 0;
        end
        do_reset();

        // Single flit from input 2, then inputs 0 and 3 race from rr_ptr=3.
        add_flit(2, 14'h1A5B);
        p_valid[2] = 100;
        repeat (3) cycle();
        add_flit(0, 14'h0001);
        add_flit(3, 14'h2C01);
        for (int i = 0; i < N; i++) p_valid[i] = 100;
        repeat (4) cycle();

        // Two competing 3-flit packets from inputs 0 and 1.
        do_reset();
        add_pkt(0, 3);
        add_pkt(1, 3);
        repeat (10) cycle();

        // All inputs streaming single-flit packets.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++) add_pkt(i, 1);
        end
        repeat (24) cycle();

        // Downstream stall while input 3 owns the output.
        for (int i = 0; i < N; i++) p_valid[i] = 0;
        p_valid[3] = 100;
        add_pkt(3, 4);
        wait_lock(3, 10);
        s0 = m_stall;
        p_ready = 0;
        repeat (5) cycle();
        p_ready = 100;
        check("stall_delta", 64'(m_stall - s0), 64'd5);
`ifdef NOC_ARB_STATS_EN
        #1;
        check("stall_count_after_5", 64'(stall_count - CW'(s0)), 64'd5);
`endif
        repeat (8) cycle();

        // Owner goes quiet mid-packet while input 0 keeps requesting.
        p_valid[0] = 100;
        add_pkt(0, 2);
        add_pkt(3, 4);
        wait_lock(3, 12);
        block_mask[3] = 1'b1;
        repeat (4) cycle();
        block_mask[3] = 1'b0;
        repeat (12) cycle();

        // Reset while locked, then arbitration restarts from pointer 0.
        p_valid[2] = 100;
        add_pkt(2, 4);
        wait_lock(2, 10);
        do_reset();
        for (int i = 0; i < N; i++) p_valid[i] = 100;
        add_pkt(1, 1);
        add_pkt(3, 1);
        repeat (5) cycle();

        // Random traffic with random valid gaps and backpressure.
        for (int i = 0; i < N; i++) p_valid[i] = 70;
        p_ready = 60;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 3) begin
                n = $urandom_range(0, N - 1);
                if (src_wr[n] - src_rd[n] < SRC_DEPTH - 8) add_pkt(n, $urandom_range(1, 4));
            end
            cycle();
        end

        // Drain everything.
        for (int i = 0; i < N; i++) p_valid[i] = 100;
        p_ready = 100;
        n = 0;
        while ((!sources_empty() || sb.size() != 0) && n < 800) begin
            cycle();
            n++;
        end
        checks++;
        if (!sources_empty() || sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending_sb=%0d sources_empty=%0d", sb.size(), sources_empty());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
